// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// datapath mux selects, ALU operation classes and RV32I opcode values.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ALU_SRC_A_PC     = 2'd0;
  localparam logic [1:0] ALU_SRC_A_REG    = 2'd1;
  localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'd2;

  localparam logic [1:0] ALU_SRC_B_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd2;

  localparam logic PC_SOURCE_ALU     = 1'b0;
  localparam logic PC_SOURCE_ALU_OUT = 1'b1;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b11;

  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unanswered memory request cycles and flags a timeout
// in the cycle that reaches MAX_MEM_WAIT (0 disables the timeout).
module mem_wait_timer #(
  parameter int unsigned MAX_MEM_WAIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic timeout
);

  localparam int unsigned W = $clog2(MAX_MEM_WAIT + 2);

  logic [W-1:0] count;

  // A waiting cycle always holds the FSM in place, so clearing on any
  // non-waiting cycle also covers every state change.
  always_ff @(posedge clk) begin
    if (reset || !waiting || MAX_MEM_WAIT == 0)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign timeout = (MAX_MEM_WAIT != 0) && waiting &&
                   (32'(count) + 32'd1 >= MAX_MEM_WAIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB) with Mealy datapath enables.
// Optional performance counters are enabled by defining CTRL_PERF_COUNTERS_EN.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W     = 2,
  parameter int unsigned MAX_MEM_WAIT = 0
`ifdef CTRL_PERF_COUNTERS_EN
  , parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  input  logic                alu_bcond,
  input  logic                halt_req,
  output logic                mem_req,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_source,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                pc_to_reg,
  output logic                halted,
  output logic                mem_error,
  output logic [2:0]          state
`ifdef CTRL_PERF_COUNTERS_EN
  , output logic [CNT_W-1:0]  cycle_count
  , output logic [CNT_W-1:0]  instret_count
`endif
);

  state_t     cur_state, next_state;
  logic [1:0] alu_class;
  logic       timeout;

  mem_wait_timer #(.MAX_MEM_WAIT(MAX_MEM_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (mem_req && !mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IF;
    else       cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IF:  if (mem_ready) next_state = S_ID;
             else if (timeout) next_state = S_ERR;
      S_ID:  if (opcode == OP_ECALL) next_state = halt_req ? S_HALT : S_IF;
             else next_state = S_EX;
      S_EX:  case (opcode)
               OP_ARITHMETIC, OP_ARITHMETIC_IMM: next_state = S_WB;
               OP_LOAD, OP_STORE:                next_state = S_MEM;
               default:                          next_state = S_IF;
             endcase
      S_MEM: if (mem_ready) next_state = (opcode == OP_LOAD) ? S_WB : S_IF;
             else if (timeout) next_state = S_ERR;
      S_WB:  next_state = S_IF;
      S_HALT, S_ERR: next_state = cur_state;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_SOURCE_ALU;
    alu_src_a  = ALU_SRC_A_PC;
    alu_src_b  = ALU_SRC_B_REG;
    alu_class  = ALU_OP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    halted     = 1'b0;
    mem_error  = 1'b0;
    case (cur_state)
      S_IF: begin
        mem_req   = 1'b1;
        alu_src_b = ALU_SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_ID: begin
        alu_src_a = ALU_SRC_A_OLD_PC;
        alu_src_b = ALU_SRC_B_IMM;
      end
      S_EX: case (opcode)
        OP_ARITHMETIC: begin
          alu_src_a = ALU_SRC_A_REG;
          alu_class = ALU_OP_RTYPE;
        end
        OP_ARITHMETIC_IMM: begin
          alu_src_a = ALU_SRC_A_REG;
          alu_src_b = ALU_SRC_B_IMM;
          alu_class = ALU_OP_ITYPE;
        end
        OP_LOAD, OP_STORE: begin
          alu_src_a = ALU_SRC_A_REG;
          alu_src_b = ALU_SRC_B_IMM;
        end
        OP_BRANCH: begin
          alu_src_a = ALU_SRC_A_REG;
          alu_class = ALU_OP_BRANCH;
          pc_source = PC_SOURCE_ALU_OUT;
          pc_write  = alu_bcond;
        end
        OP_JAL: begin
          reg_write = 1'b1;
          pc_to_reg = 1'b1;
          pc_write  = 1'b1;
          pc_source = PC_SOURCE_ALU_OUT;
        end
        OP_JALR: begin
          alu_src_a = ALU_SRC_A_REG;
          alu_src_b = ALU_SRC_B_IMM;
          reg_write = 1'b1;
          pc_to_reg = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
      S_MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
      end
      S_HALT:  halted    = 1'b1;
      S_ERR:   mem_error = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_class);
  assign state  = cur_state;

`ifdef CTRL_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (cur_state != S_HALT && cur_state != S_ERR)
        cycle_count <= cycle_count + 1'b1;
      if ((next_state == S_IF && cur_state != S_IF) ||
          (next_state == S_HALT && cur_state != S_HALT))
        instret_count <= instret_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream checked against an instruction-level trace model.
module tb_multicycle_control_unit;
  import ctrl_pkg::*;

  localparam int unsigned MAX_WAIT = 4;

  localparam logic [6:0] OPC_ADD   = 7'b0110011;
  localparam logic [6:0] OPC_ADDI  = 7'b0010011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_ECALL = 7'b1110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;

  // enable vector bit positions
  localparam int E_MREQ = 8, E_MW = 7, E_IRW = 6, E_PCW = 5, E_RW = 4;
  localparam int E_M2R = 3, E_P2R = 2, E_HALT = 1, E_ERR = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0, mem_ready = 1'b0, alu_bcond = 1'b0, halt_req = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_source;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, pc_to_reg, halted, mem_error;
  logic [2:0] state;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_OP_W(2), .MAX_MEM_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .alu_bcond(alu_bcond), .halt_req(halt_req), .mem_req(mem_req),
    .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .halted(halted),
    .mem_error(mem_error), .state(state)
`ifdef CTRL_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  function automatic logic [8:0] dut_en();
    return {mem_req, mem_write, ir_write, pc_write, reg_write,
            mem_to_reg, pc_to_reg, halted, mem_error};
  endfunction

  // Drive inputs just after a falling edge; outputs settle before sampling.
  task automatic set_in(input logic rdy, input logic [6:0] opc,
                        input logic bc, input logic hr);
    mem_ready = rdy; opcode = opc; alu_bcond = bc; halt_req = hr;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, OPC_ADD, 1'b0, 1'b0);
      @(negedge clk);
    end
    apply_reset();
    set_in(1'b0, OPC_ADD, 1'b0, 1'b0);
    n_checks++;
    if (state !== S_IF) $display("FAIL reset_state: got %0d expected %0d", state, S_IF);
    else n_pass++;
    n_checks++;
    if (dut_en() !== 9'b1_0000_0000)
      $display("FAIL reset_enables: got %b expected %b", dut_en(), 9'b1_0000_0000);
    else n_pass++;
    n_checks++;
    if ({i_or_d, pc_source, alu_src_a, alu_src_b, alu_op} !== 8'b0_0_00_01_00)
      $display("FAIL reset_selects: got %b expected %b",
               {i_or_d, pc_source, alu_src_a, alu_src_b, alu_op}, 8'b0_0_00_01_00);
    else n_pass++;
`ifdef CTRL_PERF_COUNTERS_EN
    n_checks++;
    if ({cycle_count, instret_count} !== 64'd0)
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instret_count);
    else n_pass++;
`endif
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [2:0] exp_st [5] = '{S_IF, S_ID, S_EX, S_WB, S_IF};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, OPC_ADD, 1'($urandom), 1'b0);
      n_checks++;
      if (state !== exp_st[i]) $display("FAIL add_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
      else n_pass++;
      n_checks++;
      if (reg_write !== 1'(i == 3)) $display("FAIL add_reg_write[%0d]: got %b expected %b", i, reg_write, i == 3);
      else n_pass++;
      n_checks++;
      if (pc_write !== 1'(i == 0 || i == 4)) $display("FAIL add_pc_write[%0d]: got %b expected %b", i, pc_write, i == 0 || i == 4);
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (alu_op !== 2'b10) $display("FAIL add_alu_op: got %b expected 10", alu_op);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    logic [2:0] exp_st [9] = '{S_IF, S_ID, S_EX, S_MEM, S_MEM, S_MEM, S_MEM, S_WB, S_IF};
    logic       rdy    [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      set_in(rdy[i], OPC_LW, 1'b0, 1'b0);
      n_checks++;
      if (state !== exp_st[i]) $display("FAIL load_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
      else n_pass++;
      if (exp_st[i] == S_MEM) begin
        n_checks++;
        if ({mem_req, i_or_d, mem_write} !== 3'b110)
          $display("FAIL load_mem[%0d]: got %b expected 110", i, {mem_req, i_or_d, mem_write});
        else n_pass++;
      end
      if (exp_st[i] == S_WB) begin
        n_checks++;
        if ({reg_write, mem_to_reg} !== 2'b11)
          $display("FAIL load_wb: got %b expected 11", {reg_write, mem_to_reg});
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0] exp_st [4] = '{S_IF, S_ID, S_EX, S_IF};
    for (int bc = 0; bc < 2; bc++) begin
      apply_reset();
      for (int i = 0; i < 4; i++) begin
        set_in(1'b1, OPC_BEQ, 1'(bc), 1'b0);
        n_checks++;
        if (state !== exp_st[i]) $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", bc, i, state, exp_st[i]);
        else n_pass++;
        if (i == 2) begin
          n_checks++;
          if (pc_write !== 1'(bc)) $display("FAIL beq%0d_pc_write: got %b expected %b", bc, pc_write, bc);
          else n_pass++;
          if (bc == 1) begin
            n_checks++;
            if (pc_source !== 1'b1) $display("FAIL beq_pc_source: got %b expected 1", pc_source);
            else n_pass++;
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_ecall();
    apply_reset();
    set_in(1'b1, OPC_ECALL, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, OPC_ECALL, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      set_in(1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
      n_checks++;
      if (state !== S_HALT) $display("FAIL halt_state[%0d]: got %0d expected %0d", i, state, S_HALT);
      else n_pass++;
      n_checks++;
      if (dut_en() !== 9'b0_0000_0010) $display("FAIL halt_quiet[%0d]: got %b expected 000000010", i, dut_en());
      else n_pass++;
      @(negedge clk);
    end
`ifdef CTRL_PERF_COUNTERS_EN
    n_checks++;
    if (instret_count !== 32'd1) $display("FAIL halt_instret: got %0d expected 1", instret_count);
    else n_pass++;
    n_checks++;
    if (cycle_count !== 32'd2) $display("FAIL halt_cycles: got %0d expected 2", cycle_count);
    else n_pass++;
`endif
    apply_reset();
    set_in(1'b1, OPC_ECALL, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, OPC_ECALL, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, OPC_ECALL, 1'b0, 1'b0);
    n_checks++;
    if ({state, halted} !== {S_IF, 1'b0}) $display("FAIL ecall_nohalt: got %0d/%b expected %0d/0", state, halted, S_IF);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, OPC_ADD, 1'b0, 1'b0);
      n_checks++;
      if (state !== ((i < 4) ? S_IF : S_ERR))
        $display("FAIL timeout_state[%0d]: got %0d expected %0d", i, state, (i < 4) ? S_IF : S_ERR);
      else n_pass++;
      @(negedge clk);
    end
    set_in(1'b1, OPC_ADD, 1'b0, 1'b0);
    n_checks++;
    if ({state, dut_en()} !== {S_ERR, 9'b0_0000_0001})
      $display("FAIL timeout_err: got %0d/%b expected %0d/000000001", state, dut_en(), S_ERR);
    else n_pass++;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'(i == 3), OPC_ADD, 1'b0, 1'b0);
      @(negedge clk);
    end
    set_in(1'b0, OPC_ADD, 1'b0, 1'b0);
    n_checks++;
    if (state !== S_ID) $display("FAIL timeout_ready_wins: got %0d expected %0d", state, S_ID);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_store_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, OPC_SW, 1'b0, 1'b0);
      @(negedge clk);
    end
    set_in(1'b0, OPC_SW, 1'b0, 1'b0);
    n_checks++;
    if ({state, mem_req, mem_write} !== {S_MEM, 2'b11})
      $display("FAIL store_mem: got %0d/%b expected %0d/11", state, {mem_req, mem_write}, S_MEM);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, OPC_SW, 1'b0, 1'b0);
    n_checks++;
    if ({state, mem_write, i_or_d} !== {S_IF, 2'b00})
      $display("FAIL store_reset: got %0d/%b expected %0d/00", state, {mem_write, i_or_d}, S_IF);
    else n_pass++;
`ifdef CTRL_PERF_COUNTERS_EN
    n_checks++;
    if ({cycle_count, instret_count} !== 64'd0)
      $display("FAIL store_reset_counters: got %0d/%0d expected 0/0", cycle_count, instret_count);
    else n_pass++;
`endif
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [2:0] st;
    logic       rdy;
    logic [6:0] opc;
    logic       bc;
    logic       hr;
    logic [8:0] en;
    logic       psrc;
    logic       chk_alu;
    logic [1:0] aop;
    logic [1:0] sa;
    logic [1:0] sb;
  } step_t;

  task automatic test_random();
    step_t q[$];
    step_t s;
    int unsigned n_instr = 150;
    apply_reset();
    for (int n = 0; n < int'(n_instr); n++) begin
      int unsigned cls  = $urandom_range(0, 8);
      int unsigned ifw  = $urandom_range(0, 3);
      int unsigned memw = $urandom_range(0, 3);
      logic [6:0] opc;
      case (cls)
        0: opc = OPC_ADD;   1: opc = OPC_ADDI; 2: opc = OPC_LW;
        3: opc = OPC_SW;    4: opc = OPC_BEQ;  5: opc = OPC_JAL;
        6: opc = OPC_JALR;  7: opc = OPC_ECALL;
        default: opc = OPC_FENCE;
      endcase
      // fetch: opcode is don't-care until the IR is loaded
      for (int w = 0; w <= int'(ifw); w++) begin
        s = '0;
        s.st = S_IF; s.rdy = (w == int'(ifw)); s.opc = 7'($urandom);
        s.bc = 1'($urandom); s.hr = 1'($urandom);
        s.en[E_MREQ] = 1'b1;
        s.en[E_IRW] = s.rdy; s.en[E_PCW] = s.rdy; s.psrc = 1'b0;
        s.chk_alu = 1'b1; s.aop = 2'b00; s.sa = 2'd0; s.sb = 2'd1;
        q.push_back(s);
      end
      s = '0;
      s.st = S_ID; s.rdy = 1'($urandom); s.opc = opc; s.bc = 1'($urandom);
      s.hr = (cls == 7) ? 1'b0 : 1'($urandom);
      s.chk_alu = 1'b1; s.aop = 2'b00; s.sa = 2'd2; s.sb = 2'd2;
      q.push_back(s);
      if (cls == 7) continue;
      s = '0;
      s.st = S_EX; s.rdy = 1'($urandom); s.opc = opc; s.bc = 1'($urandom); s.hr = 1'($urandom);
      case (cls)
        0: begin s.chk_alu = 1'b1; s.aop = 2'b10; s.sa = 2'd1; s.sb = 2'd0; end
        1: begin s.chk_alu = 1'b1; s.aop = 2'b01; s.sa = 2'd1; s.sb = 2'd2; end
        2, 3: begin s.chk_alu = 1'b1; s.aop = 2'b00; s.sa = 2'd1; s.sb = 2'd2; end
        4: begin s.chk_alu = 1'b1; s.aop = 2'b11; s.sa = 2'd1; s.sb = 2'd0;
                 s.en[E_PCW] = s.bc; s.psrc = 1'b1; end
        5: begin s.en[E_RW] = 1'b1; s.en[E_P2R] = 1'b1; s.en[E_PCW] = 1'b1; s.psrc = 1'b1; end
        6: begin s.en[E_RW] = 1'b1; s.en[E_P2R] = 1'b1; s.en[E_PCW] = 1'b1; s.psrc = 1'b0;
                 s.chk_alu = 1'b1; s.aop = 2'b00; s.sa = 2'd1; s.sb = 2'd2; end
        default: ;
      endcase
      q.push_back(s);
      if (cls == 2 || cls == 3) begin
        for (int w = 0; w <= int'(memw); w++) begin
          s = '0;
          s.st = S_MEM; s.rdy = (w == int'(memw)); s.opc = opc;
          s.bc = 1'($urandom); s.hr = 1'($urandom);
          s.en[E_MREQ] = 1'b1; s.en[E_MW] = (cls == 3);
          q.push_back(s);
        end
      end
      if (cls <= 2) begin
        s = '0;
        s.st = S_WB; s.rdy = 1'($urandom); s.opc = opc; s.bc = 1'($urandom); s.hr = 1'($urandom);
        s.en[E_RW] = 1'b1; s.en[E_M2R] = (cls == 2);
        q.push_back(s);
      end
    end
    foreach (q[k]) begin
      set_in(q[k].rdy, q[k].opc, q[k].bc, q[k].hr);
      n_checks++;
      if (state !== q[k].st) $display("FAIL rand_state[%0d]: got %0d expected %0d", k, state, q[k].st);
      else n_pass++;
      n_checks++;
      if (dut_en() !== q[k].en) $display("FAIL rand_enables[%0d]: got %b expected %b", k, dut_en(), q[k].en);
      else n_pass++;
      if (q[k].en[E_MREQ]) begin
        n_checks++;
        if (i_or_d !== (q[k].st == S_MEM)) $display("FAIL rand_i_or_d[%0d]: got %b expected %b", k, i_or_d, q[k].st == S_MEM);
        else n_pass++;
      end
      if (q[k].en[E_PCW]) begin
        n_checks++;
        if (pc_source !== q[k].psrc) $display("FAIL rand_pc_source[%0d]: got %b expected %b", k, pc_source, q[k].psrc);
        else n_pass++;
      end
      if (q[k].chk_alu) begin
        n_checks++;
        if ({alu_op, alu_src_a, alu_src_b} !== {q[k].aop, q[k].sa, q[k].sb})
          $display("FAIL rand_alu[%0d]: got %b expected %b", k,
                   {alu_op, alu_src_a, alu_src_b}, {q[k].aop, q[k].sa, q[k].sb});
        else n_pass++;
      end
      @(negedge clk);
    end
`ifdef CTRL_PERF_COUNTERS_EN
    #1;
    n_checks++;
    if (cycle_count !== 32'(q.size())) $display("FAIL rand_cycles: got %0d expected %0d", cycle_count, q.size());
    else n_pass++;
    n_checks++;
    if (instret_count !== 32'(n_instr)) $display("FAIL rand_instret: got %0d expected %0d", instret_count, n_instr);
    else n_pass++;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_ecall();
    test_timeout();
    test_store_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
